// File: rtl/serial_word_adder.sv
// Word-level wrapper around a one-bit full adder with registered carry: operands go in LSB-first, the sum comes back as a word.
// Optional subtract mode is enabled by defining SERIAL_WORD_ADDER_SUB_EN.
module serial_word_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_WORD_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             serial_s
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, carry_q;
   logic             s_bit, c_next, last;
   logic [WIDTH-1:0] b_load;
   logic             c_init;

`ifdef SERIAL_WORD_ADDER_SUB_EN
   // A - B is computed as A + ~B + 1; carry_out then reads as "no borrow".
   assign b_load = sub ? ~b_in : b_in;
   assign c_init = sub;
`else
   assign b_load = b_in;
   assign c_init = 1'b0;
`endif

   assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
   assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   assign last   = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      acc_d = (acc_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= b_load;
                  c_q     <= c_init;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= c_next;
               acc_q <= acc_d;
               cnt_q <= cnt_q + CW'(1);
               if (last) begin
                  sum_q   <= acc_d;
                  carry_q <= c_next;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign sum_out   = sum_q;
   assign carry_out = carry_q;
   assign serial_s  = (state_q == SHIFT) & s_bit;

endmodule
